// File: rtl/cnu_msg_expander.sv
// rtl/cnu_msg_expander.sv - serial expander of a compressed min-sum check-node result
// One captured result (min1/min2/min1_idx/signs) becomes CN_DEGREE registered extrinsic beats.
module cnu_msg_expander #(
    parameter int QUAN_SIZE = 3,
    parameter int CN_DEGREE = 6,
    parameter int IDX_WIDTH = 3
) (
    input  logic                 sys_clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [QUAN_SIZE-1:0] min1_mag,
    input  logic [QUAN_SIZE-1:0] min2_mag,
    input  logic [IDX_WIDTH-1:0] min1_idx,
    input  logic [CN_DEGREE-1:0] sign_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [QUAN_SIZE-1:0] out_mag,
    output logic                 out_sign,
    output logic [IDX_WIDTH-1:0] out_idx,
    output logic                 out_last
);

    typedef enum logic {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [QUAN_SIZE-1:0]   r_min1;
    logic [QUAN_SIZE-1:0]   r_min2;
    logic [IDX_WIDTH-1:0]   r_min1_idx;
    logic [CN_DEGREE-1:0]   r_sign_vec;
    logic                   r_sign_prod;
    logic [QUAN_SIZE-1:0]   r_out_mag;
    logic                   r_out_sign;
    logic [IDX_WIDTH-1:0]   r_out_idx;
    logic                   r_out_last;

    logic                   w_load;
    logic                   w_xfer;
    logic                   w_step;
    logic [IDX_WIDTH-1:0]   w_beat_idx;
    logic [QUAN_SIZE-1:0]   w_src_min1;
    logic [QUAN_SIZE-1:0]   w_src_min2;
    logic [IDX_WIDTH-1:0]   w_src_min1_idx;
    logic [CN_DEGREE-1:0]   w_src_sign_vec;
    logic                   w_src_sign_prod;

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next_state = S_EMIT;
            S_EMIT: if (w_xfer && r_out_last && !in_valid) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (r_state == S_EMIT);
        in_ready  = rstn & ((r_state == S_IDLE) |
                            ((r_state == S_EMIT) & out_ready & r_out_last));
    end

    assign w_load = in_valid & in_ready;
    assign w_xfer = out_valid & out_ready;
    assign w_step = w_xfer & ~r_out_last;

    // The next beat is built either from the live inputs (fresh result) or the captured copy.
    assign w_beat_idx      = w_load ? '0 : r_out_idx + IDX_WIDTH'(1);
    assign w_src_min1      = w_load ? min1_mag : r_min1;
    assign w_src_min2      = w_load ? min2_mag : r_min2;
    assign w_src_min1_idx  = w_load ? min1_idx : r_min1_idx;
    assign w_src_sign_vec  = w_load ? sign_vec : r_sign_vec;
    assign w_src_sign_prod = w_load ? ^sign_vec : r_sign_prod;

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            r_min1      <= '0;
            r_min2      <= '0;
            r_min1_idx  <= '0;
            r_sign_vec  <= '0;
            r_sign_prod <= 1'b0;
            r_out_mag   <= '0;
            r_out_sign  <= 1'b0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_load) begin
                r_min1      <= min1_mag;
                r_min2      <= min2_mag;
                r_min1_idx  <= min1_idx;
                r_sign_vec  <= sign_vec;
                r_sign_prod <= ^sign_vec;
            end
            if (w_load || w_step) begin
                r_out_mag  <= (w_beat_idx == w_src_min1_idx) ? w_src_min2 : w_src_min1;
                r_out_sign <= w_src_sign_prod ^ w_src_sign_vec[w_beat_idx];
                r_out_idx  <= w_beat_idx;
                r_out_last <= (w_beat_idx == IDX_WIDTH'(CN_DEGREE - 1));
            end
        end
    end

    assign out_mag  = r_out_mag;
    assign out_sign = r_out_sign;
    assign out_idx  = r_out_idx;
    assign out_last = r_out_last;

endmodule
